// File: rtl/fir_decim_pkg.sv
// Shared types and constants for the packet FIR decimator: FSM state type,
// default 21-tap Q15 low-pass coefficient set (sum = 32767), and trailer
// status bit positions. No ports; imported by fir_decim_avl.
package fir_decim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  localparam int DEF_TAPS = 21;

  // Symmetric low-pass, taps sum to 32767 (unity gain minus one LSB in Q15).
  localparam logic signed [15:0] DEF_COEF [DEF_TAPS] = '{
    -16'sd40, -16'sd90, -16'sd110, 16'sd0, 16'sd300, 16'sd700, 16'sd1400,
    16'sd2400, 16'sd3500, 16'sd4300, 16'sd8047, 16'sd4300, 16'sd3500,
    16'sd2400, 16'sd1400, 16'sd700, 16'sd300, 16'sd0, -16'sd110, -16'sd90,
    -16'sd40
  };

  // Trailer word: upper bits copied from the EOP word, low two bits are status.
  localparam int TRL_SHORT_BIT = 0;
  localparam int TRL_SAT_BIT   = 1;

  // Taps beyond the default set (NUM_TAPS > 21) start at zero.
  function automatic logic signed [15:0] default_coef(input int k);
    if (k >= 0 && k < DEF_TAPS) return DEF_COEF[k];
    return '0;
  endfunction

endpackage

// File: rtl/fir_decim_fifo.sv
// 4-entry output FIFO holding {sop, eop, data}, with occupancy count.
// Latency: a write is visible at rd_data/count the cycle after wr_en.
// Backpressure: the writer must respect count; writes when full are dropped.
// Ports: clk/reset, wr_en/wr_data, rd_en/rd_data (head), count (0..4).
module fir_decim_fifo #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [2:0]       count
);

  logic [WIDTH-1:0] mem_q [4];
  logic [WIDTH-1:0] mem_d [4];
  logic [1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_wr = wr_en & (cnt_q != 3'd4);
    do_rd = rd_en & (cnt_q != 3'd0);
    for (int k = 0; k < 4; k++) mem_d[k] = mem_q[k];
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_wr) begin
      mem_d[wp_q] = wr_data;
      wp_d        = wp_q + 2'd1;
    end
    if (do_rd) rp_d = rp_q + 2'd1;
    cnt_d = cnt_q + {2'b00, do_wr} - {2'b00, do_rd};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) mem_q[k] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) mem_q[k] <= mem_d[k];
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_data = mem_q[rp_q];
  assign count   = cnt_q;

endmodule

// File: rtl/fir_decim_avl.sv
// Avalon-ST packet FIR low-pass + decimator: headers pass through, payload is
// filtered and decimated by FACTOR, EOP word becomes a status trailer.
// Latency: transfer -> FIFO write 1 cycle, -> out_valid 2 cycles (FIFO empty).
// Backpressure: in_ready = fifo_count <= 2, so one word in flight never overflows.
// Ports: in_* sink, out_* source, coef_* tap writes (used only when
// FIR_COEF_LOAD_EN is defined), busy, pkt_done (trailer written to FIFO).
module fir_decim_avl import fir_decim_pkg::*; #(
  parameter int DATA_WIDTH   = 16,
  parameter int COEF_WIDTH   = 16,
  parameter int NUM_TAPS     = 21,
  parameter int FACTOR       = 2,
  parameter int HEADER_WORDS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  coef_wr,
  input  logic [5:0]            coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_wdata,
  output logic                  busy,
  output logic                  pkt_done
);

  localparam int AW = DATA_WIDTH + COEF_WIDTH + 6;
  localparam int DL = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;
  localparam logic signed [AW-1:0] RND     = AW'(1) << (COEF_WIDTH - 2);
  localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) << (DATA_WIDTH - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SAT_MIN = -(AW'(1) << (DATA_WIDTH - 1));

  state_e                       state_q, state_d;
  logic [3:0]                   hdr_cnt_q, hdr_cnt_d, ph_q, ph_d;
  logic [6:0]                   pcnt_q, pcnt_d;
  logic                         sat_q, sat_d, sop_pend_q, sop_pend_d, rdy_en_q, rdy_en_d;
  logic signed [DATA_WIDTH-1:0] taps_q [DL];
  logic signed [DATA_WIDTH-1:0] taps_d [DL];
  logic                         pipe_vld_q, pipe_vld_d, pipe_sop_q, pipe_sop_d;
  logic                         pipe_eop_q, pipe_eop_d;
  logic [DATA_WIDTH-1:0]        pipe_dat_q, pipe_dat_d;
  logic signed [COEF_WIDTH-1:0] coef [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] win [NUM_TAPS];
  logic signed [AW-1:0]         acc, rnd_sh;
  logic [DATA_WIDTH-1:0]        y_dat, trl_dat;
  logic                         y_sat, xfer, samp, samp_clr;
  logic [DATA_WIDTH+1:0]        head;
  logic [2:0]                   fifo_cnt;

`ifdef FIR_COEF_LOAD_EN
  logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] coef_d [NUM_TAPS];

  // Addresses at or above NUM_TAPS match no tap and are dropped.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      coef_d[k] = coef_q[k];
      if (coef_wr && coef_addr == 6'(k)) coef_d[k] = coef_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= COEF_WIDTH'(default_coef(k));
    else       for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= coef_d[k];
  end

  always_comb for (int k = 0; k < NUM_TAPS; k++) coef[k] = coef_q[k];
`else
  logic unused_coef;
  assign unused_coef = ^{coef_wr, coef_addr, coef_wdata};
  always_comb for (int k = 0; k < NUM_TAPS; k++) coef[k] = COEF_WIDTH'(default_coef(k));
`endif

  assign xfer     = in_valid & in_ready;
  // In IDLE the incoming sample starts a fresh window (delay line cleared at SOP).
  assign samp_clr = (state_q == IDLE);
  assign samp     = xfer & ~in_eop &
                    ((state_q == PAYLOAD) | ((state_q == IDLE) & in_sop & (HEADER_WORDS == 0)));

  // Window of the filter including the sample being accepted this cycle.
  always_comb begin
    win[0] = in_data;
    for (int k = 1; k < NUM_TAPS; k++) win[k] = samp_clr ? '0 : taps_q[k-1];
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) acc = acc + AW'(win[k]) * AW'(coef[k]);
    rnd_sh = (acc + RND) >>> (COEF_WIDTH - 1);
    y_sat  = 1'b1;
    if (rnd_sh > SAT_MAX)      y_dat = SAT_MAX[DATA_WIDTH-1:0];
    else if (rnd_sh < SAT_MIN) y_dat = SAT_MIN[DATA_WIDTH-1:0];
    else begin
      y_sat = 1'b0;
      y_dat = rnd_sh[DATA_WIDTH-1:0];
    end
  end

  // An EOP seen in IDLE is SOP+EOP: fresh flags, nothing filtered yet.
  always_comb begin
    trl_dat                = in_data;
    trl_dat[TRL_SAT_BIT]   = (state_q == IDLE) ? 1'b0 : sat_q;
    trl_dat[TRL_SHORT_BIT] = (state_q == IDLE) ? 1'b1 : (pcnt_q < 7'(NUM_TAPS));
  end

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    ph_d       = ph_q;
    pcnt_d     = pcnt_q;
    sat_d      = sat_q;
    sop_pend_d = sop_pend_q;
    rdy_en_d   = 1'b1;
    for (int k = 0; k < DL; k++) taps_d[k] = taps_q[k];
    pipe_vld_d = 1'b0;
    pipe_sop_d = 1'b0;
    pipe_eop_d = 1'b0;
    pipe_dat_d = in_data;

    if (xfer) begin
      case (state_q)
        IDLE: if (in_sop) begin
          for (int k = 0; k < DL; k++) taps_d[k] = '0;
          sat_d      = 1'b0;
          pcnt_d     = '0;
          ph_d       = '0;
          hdr_cnt_d  = '0;
          sop_pend_d = 1'b1;
          if (in_eop) begin
            pipe_vld_d = 1'b1;
            pipe_sop_d = 1'b1;
            pipe_eop_d = 1'b1;
            pipe_dat_d = trl_dat;
            sop_pend_d = 1'b0;
          end else if (HEADER_WORDS > 0) begin
            pipe_vld_d = 1'b1;
            pipe_sop_d = 1'b1;
            sop_pend_d = 1'b0;
            hdr_cnt_d  = 4'd1;
            state_d    = (HEADER_WORDS == 1) ? PAYLOAD : HEADER;
          end else begin
            state_d = PAYLOAD;
          end
        end
        HEADER: begin
          pipe_vld_d = 1'b1;
          if (in_eop) begin
            pipe_eop_d = 1'b1;
            pipe_dat_d = trl_dat;
            state_d    = IDLE;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
            if (hdr_cnt_q + 4'd1 == 4'(HEADER_WORDS)) state_d = PAYLOAD;
          end
        end
        PAYLOAD: if (in_eop) begin
          pipe_vld_d = 1'b1;
          pipe_sop_d = sop_pend_q;
          pipe_eop_d = 1'b1;
          pipe_dat_d = trl_dat;
          sop_pend_d = 1'b0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // ph_d/pcnt_d/sop_pend_d already hold the post-SOP-clear values here.
    if (samp) begin
      for (int k = 0; k < DL; k++) taps_d[k] = win[k];
      if (pcnt_d < 7'(NUM_TAPS)) pcnt_d = pcnt_d + 7'd1;
      if (ph_d == 4'(FACTOR - 1)) begin
        pipe_vld_d = 1'b1;
        pipe_sop_d = sop_pend_d;
        pipe_dat_d = y_dat;
        sop_pend_d = 1'b0;
        sat_d      = sat_d | y_sat;
        ph_d       = '0;
      end else begin
        ph_d = ph_d + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hdr_cnt_q  <= '0;
      ph_q       <= '0;
      pcnt_q     <= '0;
      sat_q      <= 1'b0;
      sop_pend_q <= 1'b0;
      rdy_en_q   <= 1'b0;
      for (int k = 0; k < DL; k++) taps_q[k] <= '0;
      pipe_vld_q <= 1'b0;
      pipe_sop_q <= 1'b0;
      pipe_eop_q <= 1'b0;
      pipe_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      ph_q       <= ph_d;
      pcnt_q     <= pcnt_d;
      sat_q      <= sat_d;
      sop_pend_q <= sop_pend_d;
      rdy_en_q   <= rdy_en_d;
      for (int k = 0; k < DL; k++) taps_q[k] <= taps_d[k];
      pipe_vld_q <= pipe_vld_d;
      pipe_sop_q <= pipe_sop_d;
      pipe_eop_q <= pipe_eop_d;
      pipe_dat_q <= pipe_dat_d;
    end
  end

  fir_decim_fifo #(.WIDTH(DATA_WIDTH + 2)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pipe_vld_q),
    .wr_data ({pipe_sop_q, pipe_eop_q, pipe_dat_q}),
    .rd_en   (out_valid & out_ready),
    .rd_data (head),
    .count   (fifo_cnt)
  );

  // rdy_en_q holds in_ready low until the first edge after reset.
  assign in_ready  = rdy_en_q & (fifo_cnt <= 3'd2);
  assign out_valid = (fifo_cnt != 3'd0);
  assign out_sop   = out_valid & head[DATA_WIDTH+1];
  assign out_eop   = out_valid & head[DATA_WIDTH];
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign busy      = (state_q != IDLE) | pipe_vld_q | out_valid;
  assign pkt_done  = pipe_vld_q & pipe_eop_q;

endmodule

// File: tb/tb_fir_decim_avl.sv
module tb_fir_decim_avl;
  localparam int N = 21, F = 2, H = 3;

  logic        clk = 1'b0;
  logic        reset, in_ready, in_valid, in_sop, in_eop;
  logic [15:0] in_data, out_data;
  logic        out_ready, out_valid, out_sop, out_eop;
  logic        coef_wr, busy, pkt_done;
  logic [5:0]  coef_addr;
  logic [15:0] coef_wdata;

  always #5 clk = ~clk;

  fir_decim_avl #(.DATA_WIDTH(16), .COEF_WIDTH(16), .NUM_TAPS(N), .FACTOR(F),
                  .HEADER_WORDS(H)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy), .pkt_done(pkt_done)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: packet-level rules on plain integers.
  int          coef [N] = '{-40, -90, -110, 0, 300, 700, 1400, 2400, 3500, 4300, 8047,
                            4300, 3500, 2400, 1400, 700, 300, 0, -110, -90, -40};
  bit          m_in_pkt = 0, m_first, m_sat;
  int          m_hcnt;
  int          m_samp [$];
  logic [17:0] exp_q [$];
  int          exp_trl = 0, got_done = 0;
  bit          rdy_rand = 0, gap_en = 0;

  function automatic void model_accept(bit s, bit e, logic [15:0] d);
    logic [15:0] t;
    longint      acc;
    int          n;
    if (!m_in_pkt) begin
      if (!s) return;
      m_in_pkt = 1; m_samp.delete(); m_sat = 0; m_first = 1; m_hcnt = 0;
    end
    if (e) begin
      t = d;
      t[1] = m_sat;
      t[0] = (m_samp.size() < N);
      exp_q.push_back({m_first, 1'b1, t});
      exp_trl++;
      m_first = 0; m_in_pkt = 0;
      return;
    end
    if (m_hcnt < H) begin
      exp_q.push_back({m_first, 1'b0, d});
      m_first = 0; m_hcnt++;
      return;
    end
    m_samp.push_back(int'($signed(d)));
    n = m_samp.size() - 1;
    if (n % F == F - 1) begin
      acc = 0;
      for (int k = 0; k < N; k++)
        if (n - k >= 0) acc += longint'(coef[k]) * longint'(m_samp[n-k]);
      acc = (acc + 16384) >>> 15;
      if (acc > 32767)       begin acc = 32767;  m_sat = 1; end
      else if (acc < -32768) begin acc = -32768; m_sat = 1; end
      exp_q.push_back({m_first, 1'b0, 16'(acc)});
      m_first = 0;
    end
  endfunction

  task automatic send(input bit s, input bit e, input logic [15:0] d);
    bit ok;
    int waitc;
    in_valid = 1; in_sop = s; in_eop = e; in_data = d;
    ok = 0; waitc = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); waitc++;
    end while (!ok && waitc < 2000);
    if (ok) model_accept(s, e, d);
    else check("in_timeout", 32'(ok), 32'd1);
    #1;
    in_valid = 0; in_sop = 0; in_eop = 0;
    if (gap_en && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic pkt_hdr();
    send(1, 0, 16'($urandom));
    for (int i = 1; i < H; i++) send(0, 0, 16'($urandom));
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 5000) begin @(posedge clk); c++; end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  logic [17:0] held;
  bit          held_vld = 0;
  initial forever begin
    @(negedge clk);
    if (reset) held_vld = 0;
    else begin
      if (pkt_done) got_done++;
      if (held_vld) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        if (out_valid) check("stall_hold", 32'({out_sop, out_eop, out_data}), 32'(held));
      end
      held_vld = 0;
      if (out_valid) begin
        if (!out_ready) begin
          held = {out_sop, out_eop, out_data}; held_vld = 1;
        end else if (exp_q.size() == 0)
          check("extra_word", 32'({out_sop, out_eop, out_data}), 32'hFFFF_FFFF);
        else
          check("out_word", 32'({out_sop, out_eop, out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1; in_valid = 0; in_sop = 0; in_eop = 0; in_data = 0; out_ready = 1;
    coef_wr = 0; coef_addr = 0; coef_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sop", 32'(out_sop), 0);
    check("rst_out_eop", 32'(out_eop), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pkt_done", 32'(pkt_done), 0);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 1);

    // Impulse response
    send(1, 0, 16'h0A01); send(0, 0, 16'h0A02); send(0, 0, 16'h0A03);
    send(0, 0, 16'h7FFF);
    repeat (41) send(0, 0, 16'h0000);
    send(0, 1, 16'h1230);
    drain();

    // DC gain; coefficient port strobes must have no effect in this build
`ifndef FIR_COEF_LOAD_EN
    coef_wr = 1; coef_addr = 6'd10; coef_wdata = 16'h0000;
`endif
    pkt_hdr();
    repeat (100) send(0, 0, 16'd1000);
    send(0, 1, 16'h4444);
    coef_wr = 0;
    drain();

    // Saturation: sign pattern matched to the taps
    pkt_hdr();
    send(0, 0, 16'h0000);
    for (int j = 1; j <= N; j++) send(0, 0, (coef[N-j] < 0) ? 16'h8000 : 16'h7FFF);
    repeat (4) send(0, 0, 16'h7FFF);
    send(0, 1, 16'h5557);
    drain();

    // Short packets and stray words
    pkt_hdr(); send(0, 1, 16'h2222);
    send(1, 0, 16'h0B01); send(0, 1, 16'hBEEF);
    send(1, 1, 16'hCAFE);
    pkt_hdr();
    repeat (7) send(0, 0, 16'($urandom));
    send(0, 1, 16'hFFFF);
    send(0, 0, 16'h1111); send(0, 1, 16'h2222);
    drain();

    // Random data with backpressure, input gaps and stray mid-packet SOP
    rdy_rand = 1; gap_en = 1;
    pkt_hdr();
    for (int i = 0; i < 200; i++) send($urandom_range(0, 49) == 0, 0, 16'($urandom));
    send(0, 1, 16'($urandom));
    for (int p = 0; p < 3; p++) begin
      int len = $urandom_range(0, 60);
      pkt_hdr();
      for (int i = 0; i < len; i++) send(0, 0, 16'($urandom));
      send(0, 1, 16'($urandom));
    end
    drain();
    rdy_rand = 0; gap_en = 0;

    // Reset in the middle of a packet
    pkt_hdr();
    repeat (10) send(0, 0, 16'($urandom));
    #3 reset = 1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_data", 32'(out_data), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    exp_q.delete(); m_in_pkt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    send(0, 0, 16'h7777);
    pkt_hdr();
    repeat (30) send(0, 0, 16'($urandom));
    send(0, 1, 16'($urandom));
    drain();

    check("trailer_count", 32'(got_done), 32'(exp_trl));
    check("busy_idle", 32'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
